// File: rtl/del_fsm_multi.sv
// Delete sub-FSM for the cache controller: key, index and flush-all deletes.
// Optional post-delete verify cycle is enabled by defining DEL_FSM_VERIFY_EN.
module del_fsm_multi #(
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES),
    parameter int LOOKUP_LAT  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [1:0]                       mode,
    input  logic [IDX_W-1:0]                 idx_req,
    input  logic                             hit,
    input  logic [NUM_ENTRIES-1:0]           hit_idx,
    input  logic [NUM_ENTRIES-1:0]           valid_vec,
    output logic                             select_out,
    output logic                             delete_out,
    output logic [NUM_ENTRIES-1:0]           idx_out,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [2:0]                       err_code,
    output logic [$clog2(NUM_ENTRIES+1)-1:0] del_count
);

    localparam int LAT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    localparam logic [1:0] MODE_KEY = 2'b00;
    localparam logic [1:0] MODE_IDX = 2'b01;
    localparam logic [1:0] MODE_ALL = 2'b10;

    localparam logic [2:0] ERR_NONE   = 3'b000;
    localparam logic [2:0] ERR_MISS   = 3'b001;
    localparam logic [2:0] ERR_INDEX  = 3'b010;
    localparam logic [2:0] ERR_MODE   = 3'b011;
`ifdef DEL_FSM_VERIFY_EN
    localparam logic [2:0] ERR_VERIFY = 3'b100;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_DELETE,
`ifdef DEL_FSM_VERIFY_EN
        ST_VERIFY,
`endif
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             mode_reg, mode_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [NUM_ENTRIES-1:0] saved_idx_reg, saved_idx_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    logic [LAT_W-1:0]       lat_cnt_reg, lat_cnt_next;
    logic [2:0]             err_code_reg, err_code_next;
    logic [CNT_W-1:0]       del_count_reg, del_count_next;

    // One-hot decodes of the flush pointer and the latched index request.
    // An out-of-range request decodes to all zeros, which reads as invalid.
    logic [NUM_ENTRIES-1:0] ptr_onehot;
    logic [NUM_ENTRIES-1:0] req_onehot;
    logic [NUM_ENTRIES-1:0] hit_lowest;
    logic                   ptr_valid;
    logic                   req_valid;

    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_decode
            assign ptr_onehot[gi] = (ptr_reg == IDX_W'(gi));
            assign req_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign hit_lowest = hit_idx & (~hit_idx + NUM_ENTRIES'(1));
    assign ptr_valid  = |(ptr_onehot & valid_vec);
    assign req_valid  = |(req_onehot & valid_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= '0;
            idx_reg       <= '0;
            saved_idx_reg <= '0;
            ptr_reg       <= '0;
            lat_cnt_reg   <= '0;
            err_code_reg  <= ERR_NONE;
            del_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            idx_reg       <= idx_next;
            saved_idx_reg <= saved_idx_next;
            ptr_reg       <= ptr_next;
            lat_cnt_reg   <= lat_cnt_next;
            err_code_reg  <= err_code_next;
            del_count_reg <= del_count_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        idx_next       = idx_reg;
        saved_idx_next = saved_idx_reg;
        ptr_next       = ptr_reg;
        lat_cnt_next   = lat_cnt_reg;
        err_code_next  = err_code_reg;
        del_count_next = del_count_reg;
        select_out     = 1'b0;
        delete_out     = 1'b0;
        idx_out        = '0;
        busy           = (state_reg != ST_IDLE);
        done           = 1'b0;
        error          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    err_code_next  = ERR_NONE;
                    del_count_next = '0;
                    mode_next      = mode;
                    idx_next       = idx_req;
                    case (mode)
                        MODE_KEY: begin
                            lat_cnt_next = LAT_W'(LOOKUP_LAT - 1);
                            state_next   = ST_LOOKUP;
                        end
                        MODE_IDX: state_next = ST_CHECK;
                        MODE_ALL: begin
                            ptr_next   = '0;
                            state_next = ST_FLUSH;
                        end
                        default: begin
                            err_code_next = ERR_MODE;
                            state_next    = ST_ERROR;
                        end
                    endcase
                end
            end

            ST_LOOKUP: begin
                if (lat_cnt_reg == '0) begin
                    state_next = ST_CHECK;
                end else begin
                    lat_cnt_next = lat_cnt_reg - LAT_W'(1);
                end
            end

            // Only KEY and IDX operations reach CHECK.
            ST_CHECK: begin
                if (mode_reg == MODE_KEY) begin
                    if (hit && (hit_idx != '0)) begin
                        saved_idx_next = hit_lowest;
                        state_next     = ST_DELETE;
                    end else begin
                        err_code_next = ERR_MISS;
                        state_next    = ST_ERROR;
                    end
                end else begin
                    if (req_valid) begin
                        saved_idx_next = req_onehot;
                        state_next     = ST_DELETE;
                    end else begin
                        err_code_next = ERR_INDEX;
                        state_next    = ST_ERROR;
                    end
                end
            end

            ST_DELETE: begin
                delete_out     = 1'b1;
                idx_out        = saved_idx_reg;
                select_out     = (mode_reg == MODE_IDX);
                del_count_next = CNT_W'(1);
`ifdef DEL_FSM_VERIFY_EN
                state_next     = ST_VERIFY;
`else
                state_next     = ST_DONE;
`endif
            end

`ifdef DEL_FSM_VERIFY_EN
            // The memory should have cleared the cell during DELETE.
            ST_VERIFY: begin
                if ((valid_vec & saved_idx_reg) != '0) begin
                    err_code_next = ERR_VERIFY;
                    state_next    = ST_ERROR;
                end else begin
                    state_next = ST_DONE;
                end
            end
`endif

            ST_FLUSH: begin
                if (ptr_valid) begin
                    delete_out     = 1'b1;
                    select_out     = 1'b1;
                    idx_out        = ptr_onehot;
                    del_count_next = del_count_reg + CNT_W'(1);
                end
                if (ptr_reg == IDX_W'(NUM_ENTRIES - 1)) begin
                    state_next = ST_DONE;
                end else begin
                    ptr_next = ptr_reg + IDX_W'(1);
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            ST_ERROR: begin
                error      = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign err_code  = err_code_reg;
    assign del_count = del_count_reg;

endmodule

// File: tb/tb_del_fsm_multi.sv
// Randomized bench for del_fsm_multi: per-cycle output trace predicted by a
// behavioural model built from the delete rules, plus directed corner cases.
module tb_del_fsm_multi;

    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int LAT = 1;
    localparam int CW  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [IW-1:0] idx_req;
    logic          hit;
    logic [N-1:0]  hit_idx;
    logic [N-1:0]  valid_vec;
    logic          select_out;
    logic          delete_out;
    logic [N-1:0]  idx_out;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    err_code;
    logic [CW-1:0] del_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    del_fsm_multi #(
        .NUM_ENTRIES(N),
        .IDX_W      (IW),
        .LOOKUP_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .idx_req   (idx_req),
        .hit       (hit),
        .hit_idx   (hit_idx),
        .valid_vec (valid_vec),
        .select_out(select_out),
        .delete_out(delete_out),
        .idx_out   (idx_out),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .del_count (del_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] pack(input logic sel, input logic del, input logic [N-1:0] idx,
                                         input logic dn, input logic er, input logic bsy);
        return {11'd0, sel, del, idx, dn, er, bsy};
    endfunction

    function automatic logic [31:0] observed();
        return pack(select_out, delete_out, idx_out, done, error, busy);
    endfunction

    // Expected per-cycle trace: cycle 0 is the start cycle, the last entry is
    // the idle cycle after the done/error pulse.
    task automatic build_trace(input logic [1:0] m, input logic [IW-1:0] ir, input logic h,
                               input logic [N-1:0] hi, input logic [N-1:0] vv,
                               output logic [2:0] ec, output int dc);
        logic [N-1:0] target;
        logic         ok;
        exp_q.delete();
        exp_q.push_back(pack(0, 0, '0, 0, 0, 0));
        ec = 3'd0;
        dc = 0;
        ok = 1'b0;
        target = '0;
        if (m == 2'b11) begin
            ec = 3'd3;
        end else if (m == 2'b10) begin
            for (int p = 0; p < N; p++) begin
                if (vv[p]) begin
                    exp_q.push_back(pack(1, 1, N'(1) << p, 0, 0, 1));
                    dc++;
                end else begin
                    exp_q.push_back(pack(0, 0, '0, 0, 0, 1));
                end
            end
            ok = 1'b1;
        end else begin
            if (m == 2'b00) begin
                for (int l = 0; l < LAT; l++) exp_q.push_back(pack(0, 0, '0, 0, 0, 1));
                for (int b = N - 1; b >= 0; b--) if (hi[b]) target = N'(1) << b;
                ok = h && (target != '0);
                if (!ok) ec = 3'd1;
            end else begin
                target = N'(1) << ir;
                ok = (int'(ir) < N) && vv[ir];
                if (!ok) ec = 3'd2;
            end
            exp_q.push_back(pack(0, 0, '0, 0, 0, 1));
            if (ok) begin
                exp_q.push_back(pack(m == 2'b01, 1, target, 0, 0, 1));
                dc = 1;
`ifdef DEL_FSM_VERIFY_EN
                exp_q.push_back(pack(0, 0, '0, 0, 0, 1));
                if ((vv & target) != '0) begin
                    ok = 1'b0;
                    ec = 3'd4;
                end
`endif
            end
        end
        exp_q.push_back(pack(0, 0, '0, ok, !ok, 1));
        exp_q.push_back(pack(0, 0, '0, 0, 0, 0));
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txn(input logic [1:0] m, input logic [IW-1:0] ir, input logic h,
                           input logic [N-1:0] hi, input logic [N-1:0] vv);
        logic [2:0] ec;
        int         dc;
        int         last;
        build_trace(m, ir, h, hi, vv, ec, dc);
        last      = exp_q.size() - 1;
        hit       = h;
        hit_idx   = hi;
        valid_vec = vv;
        for (int k = 0; k <= last; k++) begin
            if (k == 0) begin
                start   = 1'b1;
                mode    = m;
                idx_req = ir;
            end else if (k < last) begin
                start   = 1'($urandom_range(0, 1));
                mode    = 2'($urandom);
                idx_req = IW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check($sformatf("txn%0d_cyc%0d", n_txn, k), observed(), exp_q[k]);
            if (k == last) begin
                check($sformatf("txn%0d_err_code", n_txn), 32'(err_code), 32'(ec));
                check($sformatf("txn%0d_del_count", n_txn), 32'(del_count), 32'(dc));
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        $display("txn %0d mode=%0d idx_req=%0d hit=%0b hit_idx=%h valid_vec=%h cycles=%0d err_code=%0d del_count=%0d",
                 n_txn, m, ir, h, hi, vv, last, err_code, del_count);
        n_txn++;
    endtask

    task automatic reset_mid_flush();
        hit       = 1'b0;
        hit_idx   = '0;
        valid_vec = '1;
        start     = 1'b1;
        mode      = 2'b10;
        idx_req   = '0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("flush_ptr4", observed(), pack(1, 1, N'(1) << 4, 0, 0, 1));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_outputs", observed(), 32'd0);
        check("post_rst_err_code", 32'(err_code), 32'd0);
        check("post_rst_del_count", 32'(del_count), 32'd0);
        @(posedge clk);
        #1;
        $display("txn %0d reset during flush at ptr 4", n_txn);
        n_txn++;
    endtask

    initial begin
        logic [1:0]    m;
        logic [IW-1:0] ir;
        logic          h;
        logic [N-1:0]  hi;
        logic [N-1:0]  vv;

        rst       = 1'b1;
        start     = 1'b0;
        mode      = '0;
        idx_req   = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        valid_vec = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_outputs", observed(), 32'd0);
        check("reset_err_code", 32'(err_code), 32'd0);
        check("reset_del_count", 32'(del_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_txn(2'b00, 4'd0, 1'b1, 16'h0040, 16'h0000);
        run_txn(2'b00, 4'd0, 1'b1, 16'h0040, 16'h0040);
        run_txn(2'b00, 4'd0, 1'b0, 16'h0040, 16'hFFFF);
        run_txn(2'b00, 4'd0, 1'b1, 16'h0000, 16'hFFFF);
        run_txn(2'b00, 4'd0, 1'b1, 16'h8120, 16'h0000);
        run_txn(2'b01, 4'd5, 1'b0, 16'h0000, 16'h0020);
        run_txn(2'b01, 4'd5, 1'b0, 16'h0000, 16'hFFDF);
        run_txn(2'b01, 4'd15, 1'b0, 16'h0000, 16'h8000);
        run_txn(2'b10, 4'd0, 1'b0, 16'h0000, 16'h8101);
        run_txn(2'b10, 4'd0, 1'b0, 16'h0000, 16'h0000);
        run_txn(2'b10, 4'd0, 1'b0, 16'h0000, 16'hFFFF);
        run_txn(2'b11, 4'd3, 1'b1, 16'h0001, 16'h0001);
        reset_mid_flush();
        run_txn(2'b00, 4'd0, 1'b1, 16'h0002, 16'h0000);

        for (int t = 0; t < 40; t++) begin
            m  = 2'($urandom_range(0, 3));
            ir = IW'($urandom);
            h  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0:       hi = '0;
                1:       hi = N'(1) << $urandom_range(0, N - 1);
                default: hi = N'($urandom);
            endcase
            vv = N'($urandom) & N'($urandom);
            run_txn(m, ir, h, hi, vv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/del_fsm_multi.md
Name: del_fsm_multi

Overview:
- Parametrised successor delete sub-FSM for the cache controller; runs while the parent FSM is in ST_DEL.
- Supports three delete modes: by key (memory lookup), by index (direct), and flush-all (scan every valid entry).
- Adds configurable lookup latency, error codes, pulse-style done/error handshake and a deleted-entry count.
- Drives the memory block's select/delete/index command lines; reports status to the parent.

Parameters:
- NUM_ENTRIES, 16, number of memory cells; one-hot index width.
- IDX_W, $clog2(NUM_ENTRIES), width of binary index request.
- LOOKUP_LAT, 1, cycles from lookup issue to valid hit/hit_idx; legal values are 1 and up.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  2  00=KEY, 01=IDX, 10=ALL, 11=reserved.
- idx_req  in  IDX_W  binary target index for IDX mode.
- hit  in  1  memory key match.
- hit_idx  in  NUM_ENTRIES  one-hot matched cell.
- valid_vec  in  NUM_ENTRIES  per-cell occupied flags from memory.
- select_out  out  1  1=index-based access, 0=key lookup.
- delete_out  out  1  delete strobe to memory.
- idx_out  out  NUM_ENTRIES  one-hot target cell; 0 when delete_out=0.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle success pulse.
- error  out  1  one-cycle failure pulse.
- err_code  out  3  000 none, 001 key miss, 010 bad/invalid index, 011 bad mode, 100 verify fail.
- del_count  out  $clog2(NUM_ENTRIES+1)  entries deleted by the last operation.

Behaviour:
- Reset, synchronous on rst=1: state=IDLE; all outputs 0; saved_idx=0; counters 0. If reset occurs mid-operation, no delete_out is issued in the following cycle.
- States: IDLE, LOOKUP, CHECK, DELETE, VERIFY (macro only), FLUSH, DONE, ERROR.
- IDLE with start=1 clears err_code and del_count, latches mode and idx_req, then moves by mode:
  - KEY goes to LOOKUP.
  - IDX goes to CHECK.
  - ALL goes to FLUSH with ptr=0.
  - 11 goes to ERROR with err_code=011.
- start while busy is ignored.
- LOOKUP: select_out=0, delete_out=0. Stays for exactly LOOKUP_LAT cycles via a down-counter, then goes to CHECK.
- CHECK, KEY mode:
  - hit=1: saved_idx = lowest set bit of hit_idx (x & -x), go to DELETE.
  - hit=0, or hit=1 with hit_idx=0: go to ERROR with 001.
- CHECK, IDX mode:
  - idx_req < NUM_ENTRIES and valid_vec[idx_req]=1: saved_idx = onehot(idx_req), go to DELETE.
  - Otherwise: go to ERROR with 010.
- DELETE: exactly one cycle with delete_out=1, idx_out=saved_idx, select_out=1 in IDX mode and 0 in KEY mode; del_count=1. Next state is DONE, or VERIFY when the macro is defined.
- FLUSH: one cycle per ptr, ptr from 0 to NUM_ENTRIES-1.
  - If valid_vec[ptr]=1: delete_out=1, select_out=1, idx_out=onehot(ptr), del_count++.
  - After ptr=NUM_ENTRIES-1, go to DONE.
  - Always exactly NUM_ENTRIES cycles; an empty memory gives done with del_count=0 and no error.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: error=1 for one cycle, then IDLE.
- err_code and del_count hold until the next accepted start.
- Latency with LOOKUP_LAT=L:
  - KEY: start to done = L+3 cycles (LOOKUP×L, CHECK, DELETE, DONE).
  - IDX: start to done = 3 cycles.
  - ALL: start to done = NUM_ENTRIES+1 cycles.
- del_count never wraps: its maximum is NUM_ENTRIES, which fits its width.

Optional Feature:
- Macro DEL_FSM_VERIFY_EN.
- Defined: after DELETE in KEY or IDX mode, enter VERIFY for one cycle.
  - If (valid_vec & saved_idx) != 0: go to ERROR with 100; del_count stays 1.
  - Otherwise: go to DONE.
  - KEY/IDX latency grows by 1; FLUSH is unaffected.
- Undefined: the VERIFY state is absent; DELETE goes straight to DONE; code 100 is never produced.

Test Plan:
- KEY hit, LOOKUP_LAT=1: start with mode=00, hit=1, hit_idx=16'h0040 in CHECK → one cycle with delete_out=1, idx_out=16'h0040, select_out=0; done pulses at cycle 4; del_count=1; err_code=000.
- KEY miss: mode=00, hit=0 → no delete_out ever; error pulses at cycle 3; err_code=001; busy low the next cycle.
- IDX mode:
  - idx_req=5 with valid_vec bit 5 set → delete_out with idx_out=16'h0020, select_out=1, done at cycle 3.
  - idx_req=5 with bit 5 clear → error with err_code=010.
- Flush: valid_vec=16'h8101 → delete_out exactly at ptr 0, 8 and 15 with the matching one-hot idx_out; done at cycle 17; del_count=3. With valid_vec=0: done, del_count=0.
- Robustness:
  - Reserved mode=11 → error with err_code=011.
  - start asserted while busy is ignored.
  - rst=1 during FLUSH at ptr=4 → the next cycle has all outputs 0 and state IDLE.
- With DEL_FSM_VERIFY_EN defined: KEY delete of 16'h0040 while valid_vec[6] is still 1 in VERIFY → error with err_code=100.
